// File: rtl/four_bits_serial_subtractor.sv
// Bit-serial 4-bit subtractor: d = a - b computed LSB first as a + ~b + 1
// through one full-adder cell, with start/busy/done handshake and adder-style flags.
module four_bits_serial_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [4:0] d,
  output logic       c,
  output logic       o,
  output logic       z
);

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  op_a, op_a_n;
  logic [W-1:0]  op_b, op_b_n;
  logic [W-1:0]  res, res_n;
  logic          carry, carry_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, done_n;
  logic [W:0]    d_n;
  logic          c_n, o_n, z_n;

  // Single full-adder cell shared by every bit position
  logic          sum_bit;
  logic          carry_out;
  logic [W-1:0]  res_shift;

  assign sum_bit   = op_a[0] ^ op_b[0] ^ carry;
  assign carry_out = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign res_shift = {sum_bit, res[W-1:1]};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      c     <= 1'b0;
      o     <= 1'b0;
      z     <= 1'b0;
    end else begin
      state <= state_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      res   <= res_n;
      carry <= carry_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      d     <= d_n;
      c     <= c_n;
      o     <= o_n;
      z     <= z_n;
    end
  end

  // Next-state, datapath and output update
  always_comb begin
    state_n = state;
    op_a_n  = op_a;
    op_b_n  = op_b;
    res_n   = res;
    carry_n = carry;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    d_n     = d;
    c_n     = c;
    o_n     = o;
    z_n     = z;

    case (state)
      IDLE: begin
        if (start) begin
          op_a_n  = a;
          op_b_n  = ~b;
          carry_n = 1'b1;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end

      RUN: begin
        op_a_n  = {1'b0, op_a[W-1:1]};
        op_b_n  = {1'b0, op_b[W-1:1]};
        res_n   = res_shift;
        carry_n = carry_out;
        cnt_n   = cnt + CW'(1);
        // Last bit: carry is the carry into bit 3, so overflow is carry ^ carry_out
        if (cnt == CW'(W - 1)) begin
          d_n     = {~carry_out, res_shift};
          c_n     = carry_out;
          o_n     = carry ^ carry_out;
          z_n     = (res_shift == '0);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_four_bits_serial_subtractor.sv
// Scoreboard bench for four_bits_serial_subtractor: expected flags queued at issue,
// compared when done pulses; covers handshake timing, reset abort and a full sweep.
module tb_four_bits_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [4:0] d;
  logic       c;
  logic       o;
  logic       z;

  int checks;
  int failures;

  // {d[4:0], c, o, z}
  logic [7:0] sb[$];

  four_bits_serial_subtractor dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .d    (d),
    .c    (c),
    .o    (o),
    .z    (z)
  );

  always #5 clk = ~clk;

  // Arithmetic reference from integer subtraction
  function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb);
    int ua, ub, sa, sd;
    logic [3:0] d4;
    logic cc, oo, zz;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sd = sa - int'($signed(mb));
    d4 = 4'(ua - ub);
    cc = (ua >= ub);
    oo = (sd > 7) || (sd < -8);
    zz = (d4 == 4'd0);
    return {~cc, d4, cc, oo, zz};
  endfunction

  // Wait for done, checking latency, busy length, output stability and the result
  task automatic wait_result(input string name, input int exp_lat);
    int n;
    int busy_cnt;
    logic stable;
    logic [7:0] snap;
    logic [7:0] exp;
    n = 0;
    busy_cnt = 0;
    stable = 1'b1;
    snap = {d, c, o, z};
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if ({d, c, o, z} !== snap) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: no done after %0d cycles, required within %0d", name, n, exp_lat);
      return;
    end
    checks++;
    if (n !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", name, n, exp_lat);
    end
    checks++;
    if (busy_cnt !== exp_lat) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_with_done: got %b required 0", name, busy);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL %s outputs_changed_mid_op: required stable outputs before done", name);
    end
    checks++;
    if ({d, c, o, z} !== exp) begin
      failures++;
      $display("FAIL %s result: got d=%b c=%b o=%b z=%b required d=%b c=%b o=%b z=%b",
               name, d, c, o, z, exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input string name);
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    sb.push_back(model(ta, tb_v));
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tb_v;
    wait_result($sformatf("%s a=%h b=%h", name, ta, tb_v), 4);
  endtask

  task automatic check_quiet(input string name, input int cycles);
    int dn, bz;
    dn = 0;
    bz = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    checks++;
    if (dn !== 0 || bz !== 0) begin
      failures++;
      $display("FAIL %s quiet: got done_pulses=%0d busy_cycles=%0d required 0 and 0", name, dn, bz);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, d, c, o, z} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b d=%b c=%b o=%b z=%b required all 0",
               busy, done, d, c, o, z);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_op(4'd5, 4'd3, "basic_5_3");
    run_op(4'd3, 4'd5, "basic_3_5");
    run_op(4'd8, 4'd1, "ovf_8_1");
    run_op(4'd7, 4'd8, "ovf_7_8");
    run_op(4'd7, 4'd7, "zero_7_7");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    a = 4'd7;
    b = 4'd7;
    start = 1'b1;
    sb.push_back(model(4'd7, 4'd7));
    @(negedge clk);
    wait_result("b2b_first", 4);
    a = 4'd9;
    b = 4'd2;
    sb.push_back(model(4'd9, 4'd2));
    @(negedge clk);
    start = 1'b0;
    wait_result("b2b_second", 4);
    check_quiet("b2b_after", 6);
  endtask

  task automatic test_start_while_busy;
    @(negedge clk);
    a = 4'd5;
    b = 4'd3;
    start = 1'b1;
    sb.push_back(model(4'd5, 4'd3));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd0;
    b = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'hF;
    b = 4'hF;
    wait_result("ignore_busy_start", 2);
    check_quiet("ignore_busy_after", 8);
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    a = 4'd5;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, d, c, o, z} !== 10'd0) begin
      failures++;
      $display("FAIL abort_reset_state: got busy=%b done=%b d=%b c=%b o=%b z=%b required all 0",
               busy, done, d, c, o, z);
    end
    rst = 1'b0;
    check_quiet("abort_no_done", 8);
    run_op(4'd5, 4'd3, "after_abort");
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 256; i++) begin
      run_op(4'(i >> 4), 4'(i), "sweep");
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    checks = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_start_while_busy;
    test_reset_abort;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
